// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: states, opcodes and control-field encodings for multicycle_control.
// The TRAP state only exists when MCCTRL_ILLEGAL_TRAP_EN is defined.
package mc_ctrl_pkg;
  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB
`ifdef MCCTRL_ILLEGAL_TRAP_EN
    , S_TRAP
`endif
  } state_t;
  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;
  localparam logic [1:0] SRCB_REG  = 2'd0;
  localparam logic [1:0] SRCB_ONE  = 2'd1;
  localparam logic [1:0] SRCB_SEXT = 2'd2;
  localparam logic [1:0] SRCB_ZEXT = 2'd3;
  localparam logic [1:0] PC_ALU = 2'd0;
  localparam logic [1:0] PC_BR  = 2'd1;
  localparam logic [1:0] PC_JMP = 2'd2;
  typedef struct packed {
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic       mem_write;
    logic       mem_to_reg;
    logic       beq;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       ir_write;
    logic [1:0] alu_op;
    logic       illegal;
  } ctrl_t;
  function automatic logic is_legal(input logic [5:0] op);
    return op inside {OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J};
  endfunction
endpackage

// File: rtl/mc_ctrl_outdec.sv
// mc_ctrl_outdec: decodes (state, latched opcode, mem_ready) into every control output.
// Only the FETCH strobes look at mem_ready; everything else is Moore.
module mc_ctrl_outdec
  import mc_ctrl_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic           en,
  input  state_t         state,
  input  logic [OPW-1:0] op,
  input  logic           mem_ready,
  output ctrl_t          c
);
  always_comb begin
    c = '0;
    if (en)
      case (state)
        S_FETCH: begin
          c.alu_src_b = SRCB_ONE;
          c.pc_write  = mem_ready;
          c.ir_write  = mem_ready;
        end
        S_DECODE: begin
          c.alu_src_b = SRCB_SEXT;
          c.pc_write  = op == OP_J;
          c.pc_src    = op == OP_J ? PC_JMP : PC_ALU;
        end
        S_EXEC: begin
          c.alu_src_a = 1'b1;
          c.alu_src_b = (op == OP_R || op == OP_BEQ) ? SRCB_REG : SRCB_SEXT;
          c.alu_op    = op == OP_R ? ALU_FUNCT : op == OP_BEQ ? ALU_SUB : ALU_ADD;
          c.beq       = op == OP_BEQ;
          c.pc_src    = op == OP_BEQ ? PC_BR : PC_ALU;
        end
        S_MEM: c.mem_write = op == OP_SW;
        S_WB: begin
          c.reg_write  = 1'b1;
          c.reg_dst    = op == OP_R;
          c.mem_to_reg = op == OP_LW;
        end
`ifdef MCCTRL_ILLEGAL_TRAP_EN
        S_TRAP: c.illegal = 1'b1;
`endif
        default: c = '0;
      endcase
  end
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXEC/MEM/WB sequencer driving the Datapath controls.
// Define MCCTRL_ILLEGAL_TRAP_EN to lock illegal opcodes into a TRAP state until reset.
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int OPW = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [OPW-1:0] opcode,
  input  logic           mem_ready,
  output logic           SelectIns,
  output logic           RegWrite,
  output logic           RegDst,
  output logic           ALUSrcA,
  output logic           MemWrite,
  output logic           MemtoReg,
  output logic           BEQ,
  output logic [1:0]     ALUSrcB,
  output logic [1:0]     PCSrc,
  output logic           PCWrite,
  output logic           IRWrite,
  output logic [1:0]     ALUOp,
  output logic           illegal
);
`ifdef MCCTRL_ILLEGAL_TRAP_EN
  localparam state_t ILL_NEXT = S_TRAP;
`else
  localparam state_t ILL_NEXT = S_FETCH;
`endif
  state_t         state_q, state_d;
  logic [OPW-1:0] op_q, op_d;
  logic           run_q;
  ctrl_t          c;
  // run_q holds outputs and state idle for the first cycle after reset release
  always_comb begin
    op_d    = (run_q && state_q == S_FETCH && mem_ready) ? opcode : op_q;
    state_d = state_q;
    if (run_q)
      case (state_q)
        S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
        S_DECODE: state_d = op_q == OP_J ? S_FETCH : is_legal(op_q) ? S_EXEC : ILL_NEXT;
        S_EXEC:   state_d = op_q == OP_BEQ ? S_FETCH :
                            (op_q == OP_LW || op_q == OP_SW) ? S_MEM : S_WB;
        S_MEM:    state_d = !mem_ready ? S_MEM : op_q == OP_LW ? S_WB : S_FETCH;
`ifdef MCCTRL_ILLEGAL_TRAP_EN
        S_TRAP:   state_d = S_TRAP;
`endif
        default:  state_d = S_FETCH;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      run_q   <= 1'b1;
    end
  end
  mc_ctrl_outdec #(.OPW(OPW)) u_outdec (
    .en        (run_q),
    .state     (state_q),
    .op        (op_q),
    .mem_ready (mem_ready),
    .c         (c)
  );
  assign SelectIns = 1'b0;
  assign RegWrite  = c.reg_write;
  assign RegDst    = c.reg_dst;
  assign ALUSrcA   = c.alu_src_a;
  assign MemWrite  = c.mem_write;
  assign MemtoReg  = c.mem_to_reg;
  assign BEQ       = c.beq;
  assign ALUSrcB   = c.alu_src_b;
  assign PCSrc     = c.pc_src;
  assign PCWrite   = c.pc_write;
  assign IRWrite   = c.ir_write;
  assign ALUOp     = c.alu_op;
  assign illegal   = c.illegal;
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: vector table, reset/trap sequences and random instruction streams
// compared cycle by cycle with an instruction-level trace model.
module tb_multicycle_control;
  localparam logic [5:0] R = 6'h00, ADDI = 6'h08, LW = 6'h23, SW = 6'h2B, BQ = 6'h04, J = 6'h02;
  logic clk = 1'b0, rst_n = 1'b0, mem_ready = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic SelectIns, RegWrite, RegDst, ALUSrcA, MemWrite, MemtoReg, BEQ, PCWrite, IRWrite, illegal;
  logic [1:0] ALUSrcB, PCSrc, ALUOp;
  logic [15:0] got;
  int checks = 0, failures = 0;
  logic [15:0] tr_w[$];
  logic        tr_mr[$];
  logic [5:0]  tr_op[$];
  always #5 clk = ~clk;
  multicycle_control #(.OPW(6)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .SelectIns(SelectIns), .RegWrite(RegWrite), .RegDst(RegDst), .ALUSrcA(ALUSrcA),
    .MemWrite(MemWrite), .MemtoReg(MemtoReg), .BEQ(BEQ), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .ALUOp(ALUOp), .illegal(illegal)
  );
  assign got = {SelectIns, RegWrite, RegDst, ALUSrcA, MemWrite, MemtoReg, BEQ,
                ALUSrcB, PCSrc, PCWrite, IRWrite, ALUOp, illegal};
  function automatic logic [15:0] cw(input logic rw, rd, asa, mw, m2r, beq,
                                     input logic [1:0] asb, pcs,
                                     input logic pcw, irw,
                                     input logic [1:0] aop,
                                     input logic ill);
    return {1'b0, rw, rd, asa, mw, m2r, beq, asb, pcs, pcw, irw, aop, ill};
  endfunction
  function automatic logic legal(input logic [5:0] op);
    return op == R || op == ADDI || op == LW || op == SW || op == BQ || op == J;
  endfunction
  function automatic logic [5:0] junk();
    return 6'($urandom_range(0, 63));
  endfunction
  function automatic logic coin();
    return 1'($urandom_range(0, 1));
  endfunction
  task automatic push(input logic [15:0] w, input logic mr, input logic [5:0] op);
    tr_w.push_back(w);
    tr_mr.push_back(mr);
    tr_op.push_back(op);
  endtask
  // Expected per-cycle trace of one instruction given its fetch and memory wait counts
  task automatic build(input logic [5:0] op, input int fw, input int mw);
    tr_w.delete();
    tr_mr.delete();
    tr_op.delete();
    repeat (fw) push(cw(0,0,0,0,0,0, 2'd1, 2'd0, 0,0, 2'd0, 0), 1'b0, junk());
    push(cw(0,0,0,0,0,0, 2'd1, 2'd0, 1,1, 2'd0, 0), 1'b1, op);
    push(cw(0,0,0,0,0,0, 2'd2, op == J ? 2'd2 : 2'd0, op == J, 0, 2'd0, 0), coin(), junk());
    if (op == J || !legal(op)) return;
    push(cw(0,0,1,0,0, op == BQ, (op == R || op == BQ) ? 2'd0 : 2'd2, op == BQ ? 2'd1 : 2'd0,
            0,0, op == R ? 2'd2 : op == BQ ? 2'd1 : 2'd0, 0), coin(), junk());
    if (op == BQ) return;
    if (op == LW || op == SW) begin
      repeat (mw) push(cw(0,0,0, op == SW, 0,0, 2'd0, 2'd0, 0,0, 2'd0, 0), 1'b0, junk());
      push(cw(0,0,0, op == SW, 0,0, 2'd0, 2'd0, 0,0, 2'd0, 0), 1'b1, junk());
    end
    if (op == SW) return;
    push(cw(1, op == R, 0,0, op == LW, 0, 2'd0, 2'd0, 0,0, 2'd0, 0), coin(), junk());
  endtask
  task automatic check(input string name, input int idx, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%h exp=%h", name, idx, got, exp);
    end
  endtask
  task automatic drive(input logic mr, input logic [5:0] op, input logic [15:0] exp,
                       input string name, input int idx);
    @(negedge clk);
    mem_ready = mr;
    opcode = op;
    #1;
    check(name, idx, exp);
  endtask
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input int n,
                           input string name);
    build(op, fw, mw);
    for (int i = 0; i < n; i++) drive(tr_mr[i], tr_op[i], tr_w[i], name, i);
  endtask
  typedef struct {
    logic [5:0] op;
    int fw;
    int mw;
    int cyc;
  } vec_t;
  vec_t vecs[$];
  initial begin
    vecs = '{
      '{R, 0, 0, 4}, '{LW, 0, 2, 7}, '{SW, 0, 0, 4}, '{BQ, 0, 0, 3}, '{J, 0, 0, 2},
      '{ADDI, 0, 0, 4}, '{R, 2, 0, 6}, '{SW, 1, 2, 7}, '{LW, 1, 1, 7}, '{BQ, 1, 0, 4},
      '{J, 3, 0, 5}
    };
`ifndef MCCTRL_ILLEGAL_TRAP_EN
    vecs.push_back('{6'h3F, 0, 0, 2});
    vecs.push_back('{R, 0, 0, 4});
`endif
    mem_ready = 1'b1;
    opcode = J;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check("reset", 0, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release", 0, 16'h0000);
    foreach (vecs[k]) run_instr(vecs[k].op, vecs[k].fw, vecs[k].mw, vecs[k].cyc, "vec");
    // ADDI aborted in WB: RegWrite must fall as soon as rst_n does
    build(ADDI, 0, 0);
    for (int i = 0; i < 4; i++) drive(tr_mr[i], tr_op[i], tr_w[i], "addi_pre", i);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_reset", 0, 16'h0000);
    drive(1'b1, R, 16'h0000, "in_reset", 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("release2", 0, 16'h0000);
    run_instr(R, 0, 0, 4, "resume");
`ifdef MCCTRL_ILLEGAL_TRAP_EN
    run_instr(6'h3F, 0, 0, 2, "trap_entry");
    for (int i = 0; i < 6; i++) drive(coin(), junk(), 16'h0001, "trap_hold", i);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("trap_reset", 0, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("trap_release", 0, 16'h0000);
    run_instr(J, 0, 0, 2, "after_trap");
`endif
    for (int n = 0; n < 60; n++) begin
      logic [5:0] op;
      int sel;
`ifdef MCCTRL_ILLEGAL_TRAP_EN
      sel = $urandom_range(0, 5);
`else
      sel = $urandom_range(0, 6);
`endif
      op = sel == 0 ? R : sel == 1 ? ADDI : sel == 2 ? LW : sel == 3 ? SW :
           sel == 4 ? BQ : sel == 5 ? J : junk();
`ifdef MCCTRL_ILLEGAL_TRAP_EN
      if (!legal(op)) op = R;
`endif
      build(op, $urandom_range(0, 3), $urandom_range(0, 3));
      for (int i = 0; i < tr_w.size(); i++) drive(tr_mr[i], tr_op[i], tr_w[i], "rand", n);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
